// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned DEPTH_DEF  = 32;
    localparam int unsigned NUM_RD_DEF = 2;
    localparam int unsigned ZERO_REG   = 0;

    // Busy count must hold 0..DEPTH-1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/reg_file_sb_rdport.sv
// One combinational read port: address mux, r0 zero check, optional write forwarding.
// Forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module reg_file_sb_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][XLEN-1:0] i_regs,
    input  logic [DEPTH-1:0]           i_busy,
    input  logic [AW-1:0]              i_addr,
    input  logic                       i_wr_en,
    input  logic [AW-1:0]              i_wr_addr,
    input  logic [XLEN-1:0]            i_wr_data,
    input  logic                       i_iss_en,
    input  logic [AW-1:0]              i_iss_addr,
    output logic [XLEN-1:0]            o_data_c,
    output logic                       o_busy_c
);

    logic w_zero;
    assign w_zero = (i_addr == AW'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    logic w_iss_hit;
    assign w_fwd     = i_wr_en && (i_wr_addr == i_addr) && !w_zero;
    assign w_iss_hit = i_iss_en && (i_iss_addr == i_addr);

    // A same-cycle issue to the forwarded register keeps the stored busy bit.
    always_comb begin
        o_data_c = w_zero ? '0 : i_regs[i_addr];
        o_busy_c = w_zero ? 1'b0 : i_busy[i_addr];
        if (w_fwd) begin
            o_data_c = i_wr_data;
            if (!w_iss_hit) begin
                o_busy_c = 1'b0;
            end
        end
    end
`else
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_wr_en, i_wr_addr, i_wr_data, i_iss_en, i_iss_addr};

    always_comb begin
        o_data_c = w_zero ? '0 : i_regs[i_addr];
        o_busy_c = w_zero ? 1'b0 : i_busy[i_addr];
    end
`endif

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, flush and registered busy count.
// Optional write-to-read forwarding in the read ports via REGFILE_BYPASS_EN.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    output logic [AW:0]            busy_cnt
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic [DEPTH-1:0][XLEN-1:0] r_regs;
    logic [DEPTH-1:0]           r_busy;
    logic [DEPTH-1:0]           w_busy_nxt;
    logic [CW-1:0]              r_busy_cnt;
    logic [CW-1:0]              w_cnt_nxt;
    logic                       w_fwd_wr_en;

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
        end else if (wr_en && (wr_addr != AW'(ZERO_REG))) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Flush beats issue, issue beats writeback (newer producer stays outstanding).
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = '0;
        for (int unsigned r = 1; r < DEPTH; r++) begin
            if (flush) begin
                w_busy_nxt[r] = 1'b0;
            end else if (iss_en && (iss_addr == AW'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(r))) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign busy_cnt = r_busy_cnt;

    // Forwarding must not leak write data while reset is holding outputs at zero.
    assign w_fwd_wr_en = wr_en & ~rst;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_file_sb_rdport #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rdport (
            .i_regs     (r_regs),
            .i_busy     (r_busy),
            .i_addr     (rd_addr[i*AW +: AW]),
            .i_wr_en    (w_fwd_wr_en),
            .i_wr_addr  (wr_addr),
            .i_wr_data  (wr_data),
            .i_iss_en   (iss_en),
            .i_iss_addr (iss_addr),
            .o_data_c   (rd_data[i*XLEN +: XLEN]),
            .o_busy_c   (rd_busy[i])
        );
    end

endmodule
